// File: rtl/demux_route.sv
`default_nettype none
// ============================================================================
// demux_route : routes one valid/ready input stream to three one-entry output
// channels by priority select (sel1 > sel2 > sel3); unselected words are
// dropped and counted. Optional assertions: define DEMUX_ROUTE_ASSERT_EN.
// Revision: 1.0
// ============================================================================
module demux_route #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             sel3,
  output logic [WIDTH-1:0] op1_data,
  output logic             op1_valid,
  input  logic             op1_ready,
  output logic [WIDTH-1:0] op2_data,
  output logic             op2_valid,
  input  logic             op2_ready,
  output logic [WIDTH-1:0] op3_data,
  output logic             op3_valid,
  input  logic             op3_ready,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       tgt_oh;
  logic             tgt_none;
  logic [2:0]       ch_ready;
  logic [2:0]       ch_valid;
  logic [2:0]       load;
  logic [WIDTH-1:0] ch_data [3];
  logic [CNT_W-1:0] drop_q;

  assign ch_ready = {op3_ready, op2_ready, op1_ready};

  // Only the highest-priority asserted select survives the decode.
  always_comb begin
    tgt_oh = 3'b000;
    if (sel1)      tgt_oh = 3'b001;
    else if (sel2) tgt_oh = 3'b010;
    else if (sel3) tgt_oh = 3'b100;
  end

  assign tgt_none = (tgt_oh == 3'b000);
  assign in_ready = tgt_none | (|(tgt_oh & (~ch_valid | ch_ready)));
  assign load     = (in_valid && in_ready) ? tgt_oh : 3'b000;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_ch
      ch_state_e        state_q;
      ch_state_e        state_d;
      logic [WIDTH-1:0] data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          if (load[k]) data_q <= in_data;
        end
      end

      always_comb begin
        state_d = state_q;
        case (state_q)
          EMPTY:   if (load[k]) state_d = FULL;
          FULL:    if (ch_ready[k] && !load[k]) state_d = EMPTY;
          default: state_d = EMPTY;
        endcase
      end

      assign ch_valid[k] = (state_q == FULL);
      assign ch_data[k]  = data_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (in_valid && tgt_none && (drop_q != CNT_MAX)) begin
      drop_q <= drop_q + CNT_ONE;
    end
  end

  assign op1_data  = ch_data[0];
  assign op2_data  = ch_data[1];
  assign op3_data  = ch_data[2];
  assign op1_valid = ch_valid[0];
  assign op2_valid = ch_valid[1];
  assign op3_valid = ch_valid[2];
  assign drop_cnt  = drop_q;

`ifdef DEMUX_ROUTE_ASSERT_EN
  generate
    for (genvar k = 0; k < 3; k++) begin : g_assert
      a_load_lands: assert property (@(posedge clk) disable iff (!rst_n)
        load[k] |=> ch_valid[k] && (ch_data[k] == $past(in_data)));
      a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ch_valid[k] && !ch_ready[k] |=> ch_valid[k] && $stable(ch_data[k]));
    end
  endgenerate

  a_one_load: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(load));

  a_drop_inc: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid && tgt_none && (drop_q != CNT_MAX) |=> drop_q == $past(drop_q) + CNT_ONE);
`else
`endif

endmodule
`default_nettype wire

// File: doc/demux_route.md
Name: demux_route

Overview:
- Inverse of the team's registered priority mux.
- Takes one input stream and routes each accepted word to one of three output channels.
- Routing uses the same priority rule: sel1 > sel2 > sel3.
- Each output channel has a one-entry holding register with a valid/ready handshake.
- Words arriving with no select asserted are dropped and counted.

Parameters:
- WIDTH, 4, data width of input and all outputs.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- sel1  input  1  route to channel 1 (highest priority).
- sel2  input  1  route to channel 2.
- sel3  input  1  route to channel 3 (lowest priority).
- op1_data  output  WIDTH  channel 1 held word.
- op1_valid  output  1  channel 1 holds a word.
- op1_ready  input  1  channel 1 consumer takes the word.
- op2_data  output  WIDTH  channel 2 held word.
- op2_valid  output  1  channel 2 holds a word.
- op2_ready  input  1  channel 2 consumer takes the word.
- op3_data  output  WIDTH  channel 3 held word.
- op3_valid  output  1  channel 3 holds a word.
- op3_ready  input  1  channel 3 consumer takes the word.
- drop_cnt  output  CNT_W  number of words accepted with no select asserted.

Behaviour:
- Reset (async, rst_n=0): opK_valid=0, opK_data=0, drop_cnt=0. Applies immediately and mid-transfer; held words are discarded.
- Target decode (combinational, same cycle as in_valid): tgt=1 if sel1; else 2 if sel2; else 3 if sel3; else NONE.
- Per-channel state machine, K=1..3:
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on a drain (opK_valid & opK_ready) with no load.
  - FULL -> FULL on a load plus simultaneous drain.
  - opK_valid is 1 exactly in FULL.
- Load into K: in_valid & in_ready & tgt==K. opK_data <= in_data at the clock edge.
- in_ready (combinational):
  - tgt==NONE: 1.
  - Otherwise: (!opK_valid) | opK_ready for K=tgt. Pass-through drain/load is allowed in the same cycle.
  - in_ready does not depend on in_valid.
- Latency: word accepted at edge N appears with opK_valid=1 after edge N, i.e. one cycle. Throughput is one word/cycle per channel if the consumer keeps opK_ready=1.
- opK_data is stable while opK_valid=1 and opK_ready=0.
- Non-target channels are unaffected by an accept; they only drain.
- Drop: in_valid & tgt==NONE increments drop_cnt at the edge. drop_cnt saturates at 2^CNT_W-1 and does not wrap.
- Only the highest-priority asserted select matters. Example: sel1=sel2=1 routes to ch1 only, and back-pressure is judged on ch1 only.
- in_valid=0: no load, no drop. Selects are ignored.
- An empty channel's opK_ready is ignored.

Optional Feature:
- Macro DEMUX_ROUTE_ASSERT_EN.
- When defined, the module contains concurrent assertions clocked on posedge clk, disabled while !rst_n:
  - a) accept with tgt==K |=> opK_valid && opK_data == $past(in_data).
  - b) opK_valid && !opK_ready |=> opK_valid && $stable(opK_data).
  - c) at most one channel is loaded per cycle.
  - d) in_valid && tgt==NONE && drop_cnt != max |=> drop_cnt == $past(drop_cnt)+1.
- When not defined: no assertion code is compiled and functional behaviour is identical.

Test Plan:
- Reset with all inputs 0, then release rst_n. Expected: all opK_valid=0, in_ready=1, drop_cnt=0.
- in_data=4'hA, sel1=sel2=sel3=1, in_valid=1 for one cycle. Expected next cycle: op1_valid=1, op1_data=A, op2_valid=op3_valid=0.
- ch2 FULL with 4'h3, op2_ready=0; then send 4'h5 with sel2=1. Expected: in_ready=0, op2_data stays 3. Raise op2_ready: same cycle in_ready=1, next cycle op2_data=5, op2_valid=1.
- Stream 4'h1, 4'h2, 4'h3 on sel3 on consecutive cycles with op3_ready=1. Expected: op3_data = 1, 2, 3 on consecutive cycles, no stall.
- CNT_W=2, 5 words with no select. Expected: drop_cnt goes 1, 2, 3, 3, 3 and no channel is loaded.
- rst_n=0 asynchronously while op1_valid=1 and op3_valid=1. Expected: both valids 0 immediately, before the next clock edge.
